// File: rtl/aca_ctrl_pkg.sv
// Shared types and defaults for the ACA-CSU adder sequencer.
package aca_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPROX = 2'd1,
        EXACT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_APPROX = 2'd0;
    localparam logic [1:0] MODE_EXACT  = 2'd1;
    localparam logic [1:0] MODE_CHECK  = 2'd2;

    localparam int ACA_W     = 32;
    localparam int ACA_CHUNK = 8;
    localparam int ACA_CNT_W = 16;

    // The unused encoding 3 behaves exactly like CHECK.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_CHECK : m;
    endfunction

endpackage

// File: rtl/aca_add_ctrl_if.sv
// Producer / adder / consumer signal bundle of the adder sequencer.
interface aca_add_ctrl_if
    import aca_ctrl_pkg::*;
#(
    parameter int W     = ACA_W,
    parameter int CNT_W = ACA_CNT_W
);
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W:0]       add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [W:0]       out_sum;
    logic             out_err;
    logic             clr_cnt;
    logic [CNT_W-1:0] op_cnt;
    logic [CNT_W-1:0] err_cnt;

    // Environment side: producer, external adder and consumer.
    modport master (
        output mode, in_valid, in_a, in_b, add_sum, out_ready, clr_cnt,
        input  in_ready, add_a, add_b, out_valid, out_sum, out_err, op_cnt, err_cnt
    );

    modport slave (
        input  mode, in_valid, in_a, in_b, add_sum, out_ready, clr_cnt,
        output in_ready, add_a, add_b, out_valid, out_sum, out_err, op_cnt, err_cnt
    );

endinterface

// File: rtl/aca_chunk_add.sv
// CHUNK-bit ripple-carry adder slice, reused every EXACT cycle.
module aca_chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[CHUNK];
    end

endmodule

// File: rtl/aca_add_ctrl.sv
// Sequencer for the external approximate adder: latches operands, optionally
// rebuilds the exact sum chunk by chunk, flags mismatches and counts results.
module aca_add_ctrl
    import aca_ctrl_pkg::*;
#(
    parameter int W     = ACA_W,
    parameter int CHUNK = ACA_CHUNK,
    parameter int CNT_W = ACA_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    aca_add_ctrl_if.slave bus
);

    // W must be a whole number of chunks.
    localparam int NCH   = W / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCH - 1);

    state_t           state;
    logic [1:0]       mode_r;
    logic [W:0]       approx_r;
    logic [W:0]       exact_r;
    logic [W:0]       exact_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [CHUNK-1:0] ch_a;
    logic [CHUNK-1:0] ch_b;
    logic [CHUNK-1:0] ch_s;
    logic             ch_co;
    logic             hs;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign hs            = bus.out_valid & bus.out_ready;

    assign ch_a = bus.add_a[idx*CHUNK +: CHUNK];
    assign ch_b = bus.add_b[idx*CHUNK +: CHUNK];

    aca_chunk_add #(.CHUNK(CHUNK)) u_chunk (
        .a    (ch_a),
        .b    (ch_b),
        .cin  (carry),
        .sum  (ch_s),
        .cout (ch_co)
    );

    // Bit W tracks the running carry so it is already correct after the last chunk.
    always_comb begin
        exact_nxt                      = exact_r;
        exact_nxt[idx*CHUNK +: CHUNK]  = ch_s;
        exact_nxt[W]                   = ch_co;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_r      <= MODE_APPROX;
            bus.add_a   <= '0;
            bus.add_b   <= '0;
            approx_r    <= '0;
            exact_r     <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            bus.out_sum <= '0;
            bus.out_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.add_a <= bus.in_a;
                        bus.add_b <= bus.in_b;
                        mode_r    <= norm_mode(bus.mode);
                        state     <= APPROX;
                    end
                end
                APPROX: begin
                    approx_r <= bus.add_sum;
                    idx      <= '0;
                    carry    <= 1'b0;
                    if (mode_r == MODE_APPROX) begin
                        bus.out_sum <= bus.add_sum;
                        bus.out_err <= 1'b0;
                        state       <= DONE;
                    end else begin
                        state <= EXACT;
                    end
                end
                EXACT: begin
                    exact_r <= exact_nxt;
                    carry   <= ch_co;
                    idx     <= idx + 1'b1;
                    if (idx == LAST) begin
                        bus.out_sum <= exact_nxt;
                        bus.out_err <= (mode_r == MODE_CHECK) && (exact_nxt != approx_r);
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear wins over a coincident increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.op_cnt  <= '0;
            bus.err_cnt <= '0;
        end else if (bus.clr_cnt) begin
            bus.op_cnt  <= '0;
            bus.err_cnt <= '0;
        end else if (hs) begin
            if (bus.op_cnt != '1)                bus.op_cnt  <= bus.op_cnt + 1'b1;
            if (bus.out_err && bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_aca_add_ctrl.sv
// Self-checking bench for aca_add_ctrl: vector table, stall/overlap, random, saturation, reset.
module tb_aca_add_ctrl;
    import aca_ctrl_pkg::*;

    localparam int W     = 32;
    localparam int CHUNK = 8;
    localparam int CNT_W = 6;
    localparam int XLAT  = 2 + W / CHUNK;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aca_add_ctrl_if #(.W(W), .CNT_W(CNT_W)) bus ();

    aca_add_ctrl #(.W(W), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External adder stand-in: exact sum with injectable bit flips, or a fixed override.
    logic       ovr_en;
    logic [W:0] ovr_val;
    logic [W:0] err_mask;
    always_comb bus.add_sum = ovr_en ? ovr_val
                            : (({1'b0, bus.add_a} + {1'b0, bus.add_b}) ^ err_mask);

    int n_chk  = 0;
    int n_pass = 0;
    logic [CNT_W-1:0] ref_op  = '0;
    logic [CNT_W-1:0] ref_err = '0;

    typedef struct {
        logic [1:0]   m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ovr;
        logic [W:0]   add_sum;
        logic [W:0]   sum;
        logic         err;
        int           lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [W:0] ref_exact(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic cnt_upd(input logic err, input logic clr);
        if (clr) begin
            ref_op  = '0;
            ref_err = '0;
        end else begin
            if (ref_op != CMAX) ref_op = ref_op + 1'b1;
            if (err && ref_err != CMAX) ref_err = ref_err + 1'b1;
        end
    endtask

    // Called at a negedge with the DUT idle; runs one full transaction and checks it.
    task automatic run_txn(input string nm, input logic [1:0] m, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int hold, input logic clr,
                           input logic [W:0] exp_sum, input logic exp_err, input int exp_lat);
        int         lat;
        logic       stable;
        logic [W:0] s;
        logic       e;
        chk({nm, ".rdy"}, 64'(bus.in_ready), 64'(1));
        bus.mode = m; bus.in_a = a; bus.in_b = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        lat = 0; stable = 1'b1;
        do begin
            @(posedge clk); lat++;
            @(negedge clk); bus.in_valid = 1'b0;
            if (bus.add_a !== a || bus.add_b !== b) stable = 1'b0;
        end while (!bus.out_valid && lat < 40);
        chk({nm, ".lat"}, 64'(lat), 64'(exp_lat));
        s = bus.out_sum; e = bus.out_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            if (bus.out_sum !== s || bus.out_err !== e || bus.out_valid !== 1'b1 ||
                bus.in_ready !== 1'b0 || bus.add_a !== a || bus.add_b !== b) stable = 1'b0;
        end
        chk({nm, ".sum"}, 64'(s), 64'(exp_sum));
        chk({nm, ".err"}, 64'(e), 64'(exp_err));
        chk({nm, ".stable"}, 64'(stable), 64'(1));
        bus.out_ready = 1'b1; bus.clr_cnt = clr;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0; bus.clr_cnt = 1'b0;
        cnt_upd(exp_err, clr);
        chk({nm, ".idle"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
        chk({nm, ".op_cnt"}, 64'(bus.op_cnt), 64'(ref_op));
        chk({nm, ".err_cnt"}, 64'(bus.err_cnt), 64'(ref_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [7];
        logic [1:0]   m;
        logic [W-1:0] a, b;
        logic [W:0]   ex, ap, msk;
        logic         flag;
        int           lat;

        bus.mode = '0; bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.out_ready = 1'b0; bus.clr_cnt = 1'b0;
        ovr_en = 1'b0; ovr_val = '0; err_mask = '0;

        repeat (3) @(negedge clk);
        chk("rst.in_ready",  64'(bus.in_ready),  64'(1));
        chk("rst.out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst.out_sum",   64'(bus.out_sum),   64'(0));
        chk("rst.out_err",   64'(bus.out_err),   64'(0));
        chk("rst.add_ab",    64'({bus.add_a, bus.add_b}), 64'(0));
        chk("rst.cnts",      64'({bus.op_cnt, bus.err_cnt}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0] = '{MODE_APPROX, 32'h0000_0003, 32'h0000_0005, 1'b1, 33'h0_0000_0008, 33'h0_0000_0008, 1'b0, 2};
        tbl[1] = '{MODE_CHECK,  32'h0000_00FF, 32'h0000_0001, 1'b1, 33'h0_0000_00F0, 33'h0_0000_0100, 1'b1, XLAT};
        tbl[2] = '{MODE_EXACT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h0_0000_0000, 33'h1_FFFF_FFFE, 1'b0, XLAT};
        tbl[3] = '{2'd3,        32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0000, 33'h1_0000_0000, 1'b0, XLAT};
        tbl[4] = '{MODE_APPROX, 32'h0000_0001, 32'h0000_0001, 1'b1, 33'h0_0000_0005, 33'h0_0000_0005, 1'b0, 2};
        tbl[5] = '{MODE_CHECK,  32'h1234_5678, 32'h0FED_CBA9, 1'b1, 33'h0_2222_2221, 33'h0_2222_2221, 1'b0, XLAT};
        tbl[6] = '{2'd3,        32'h0000_FFFF, 32'h0000_0001, 1'b1, 33'h0_0000_FF00, 33'h0_0001_0000, 1'b1, XLAT};
        for (int i = 0; i < 7; i++) begin
            ovr_en  = tbl[i].ovr;
            ovr_val = tbl[i].add_sum;
            run_txn($sformatf("vec%0d", i), tbl[i].m, tbl[i].a, tbl[i].b, (i == 2) ? 3 : 0, 1'b0,
                    tbl[i].sum, tbl[i].err, tbl[i].lat);
        end
        ovr_en = 1'b0;

        // A second operand waits, valid, while the first result is stalled.
        bus.mode = MODE_APPROX; bus.in_a = 32'd10; bus.in_b = 32'd20; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_a = 32'd100; bus.in_b = 32'd200;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin @(posedge clk); @(negedge clk); lat++; end
        chk("hold.lat", 64'(lat), 64'(1));
        flag = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); @(negedge clk);
            if (bus.out_sum !== 33'd30 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.add_a !== 32'd10) flag = 1'b0;
        end
        chk("hold.stall", 64'(flag), 64'(1));
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        cnt_upd(1'b0, 1'b0);
        chk("hold.after_hs", 64'({bus.in_ready, bus.out_valid, bus.add_a}), 64'({1'b1, 1'b0, 32'd10}));
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        chk("hold.second_acc", 64'(bus.add_a), 64'(100));
        lat = 0;
        while (!bus.out_valid && lat < 10) begin @(posedge clk); @(negedge clk); lat++; end
        chk("hold.second_sum", 64'(bus.out_sum), 64'(300));
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        cnt_upd(1'b0, 1'b0);
        chk("hold.op_cnt", 64'(bus.op_cnt), 64'(ref_op));

        // Random operands and modes against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            m   = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            msk = ($urandom_range(0, 1) == 1) ? {1'($urandom_range(0, 1)), 32'($urandom)} : '0;
            err_mask = msk;
            ex = ref_exact(a, b);
            ap = ex ^ msk;
            run_txn($sformatf("rnd%0d", i), m, a, b, int'($urandom_range(0, 2)), 1'b0,
                    (m == MODE_APPROX) ? ap : ex, (m >= MODE_CHECK) && (ap != ex),
                    (m == MODE_APPROX) ? 2 : XLAT);
        end

        // Fill err_cnt to its ceiling, then one more error must not wrap.
        err_mask = 33'h1;
        while (ref_err != CMAX) begin
            a = $urandom; b = $urandom;
            run_txn("satfill", MODE_CHECK, a, b, 0, 1'b0, ref_exact(a, b), 1'b1, XLAT);
        end
        a = $urandom; b = $urandom;
        run_txn("sat", MODE_CHECK, a, b, 0, 1'b0, ref_exact(a, b), 1'b1, XLAT);
        chk("sat.err_max", 64'(bus.err_cnt), 64'(CMAX));
        chk("sat.op_max",  64'(bus.op_cnt),  64'(CMAX));
        run_txn("clr", MODE_CHECK, a, b, 1, 1'b1, ref_exact(a, b), 1'b1, XLAT);
        err_mask = '0;

        // Reset in the middle of EXACT (idx=2) drops the transaction.
        bus.mode = MODE_EXACT; bus.in_a = 32'hDEAD_BEEF; bus.in_b = 32'h1234_5678; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst.out_sum",   64'(bus.out_sum),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cnt_upd(1'b0, 1'b1);
        flag = 1'b1;
        bus.out_ready = 1'b1;
        for (int h = 0; h < 10; h++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) flag = 1'b0;
        end
        bus.out_ready = 1'b0;
        chk("midrst.no_result", 64'(flag), 64'(1));
        chk("midrst.cnts", 64'({bus.op_cnt, bus.err_cnt}), 64'(0));
        run_txn("post_rst", MODE_EXACT, 32'h0000_0010, 32'h0000_0020, 0, 1'b0, 33'h30, 1'b0, XLAT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aca_add_ctrl.md
Name: aca_add_ctrl

Overview:
- Sequencer for the 32-bit approximate adder (ACA-CSU).
- Accepts operand pairs over a valid/ready handshake and drives the external approximate adder with stable operands.
- Optionally computes the exact sum over several cycles with an internal chunked ripple adder, flags approximation errors and keeps saturating operation/error counters.
- Sits between the operand producer and the result consumer; the adder itself stays combinational outside this block.

Parameters:
- W, 32, operand width; must equal the external adder width.
- CHUNK, 8, bits added per exact-correction cycle; W % CHUNK == 0 is required.
- CNT_W, 16, width of the saturating counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  sampled on accept. 0 = APPROX, 1 = EXACT, 2 = CHECK, 3 = treated as CHECK.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept operands.
- in_a, in_b  in  W  operands.
- add_a, add_b  out  W  operands presented to the external approximate adder.
- add_sum  in  W+1  combinational approximate sum returned by the external adder.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W+1  result.
- out_err  out  1  approximate result differed from exact (CHECK mode only).
- clr_cnt  in  1  synchronous clear of both counters.
- op_cnt  out  CNT_W  completed transactions, saturating.
- err_cnt  out  CNT_W  transactions with out_err=1, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - add_a, add_b, out_sum, out_err, op_cnt, err_cnt, and internal approx/exact registers all 0.
  - out_valid=0; in_ready=1 once state is IDLE (decoded from state).
- Reset mid-transaction discards it; no result is emitted.
- in_ready = (state==IDLE). Exactly one transaction is in flight; no overlap.
- IDLE:
  - Accept on in_valid & in_ready.
  - Latch in_a→add_a, in_b→add_b, and mode (3 mapped to 2). Go to APPROX.
- APPROX (1 cycle):
  - Register add_sum into approx_r.
  - If mode=0, go to DONE. Otherwise go to EXACT with idx=0, carry=0.
- EXACT (W/CHUNK cycles):
  - Each cycle, chunk adder computes add_a[idx]+add_b[idx]+carry. Write the CHUNK result bits into exact_r[idx], update carry, idx++.
  - After the last chunk, set exact_r[W]=carry and go to DONE.
- add_a and add_b are held stable from accept until leaving DONE.
- DONE:
  - out_valid=1.
  - out_sum = approx_r (mode 0) or exact_r (modes 1, 2).
  - out_err = (approx_r != exact_r) in mode 2; 0 otherwise.
  - Outputs are held stable until out_ready. The handshake may occur in the first DONE cycle.
- On out_valid & out_ready:
  - op_cnt++.
  - err_cnt++ if out_err.
  - Go to IDLE; out_valid=0 the next cycle.
- out_sum and out_err keep their last values while in IDLE.
- Latency from accept edge to out_valid=1: mode 0 is 2 cycles; modes 1 and 2 are 2+W/CHUNK cycles (6 at defaults).
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt has priority over a same-cycle increment (result 0).
- in_valid while busy is ignored; the producer holds its data until in_ready.
- Arithmetic:
  - Exact sum is unsigned W+1 bits. Carry-out goes in bit W.
  - Comparison covers all W+1 bits.

Decomposition:
- Package aca_ctrl_pkg:
  - State enum {IDLE, APPROX, EXACT, DONE}.
  - MODE_APPROX=2'd0, MODE_EXACT=2'd1, MODE_CHECK=2'd2.
  - Default CHUNK and CNT_W.
- Sub-module aca_chunk_add: combinational CHUNK-bit ripple adder with cin/cout, instantiated once and reused per cycle via idx muxing.

Test Plan:
- Reset then mode=0, a=0x0000_0003, b=0x0000_0005, model returns add_sum=0x8 → out_valid 2 cycles after accept, out_sum=0x0_0000_0008, out_err=0, op_cnt=1.
- mode=2, a=0x0000_00FF, b=0x0000_0001, model returns add_sum=0x0F0 → out_valid after 6 cycles, out_sum=0x100, out_err=1, err_cnt=1.
- mode=1, a=b=0xFFFF_FFFF → out_sum=0x1_FFFF_FFFE, out_err=0 even with a wrong add_sum; add_a and add_b remain stable throughout.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 → out_sum stable, in_ready=0, second operand not accepted until the cycle after the handshake.
- Preload err_cnt to max via 2^16 CHECK errors (or force), then another error → err_cnt stays 0xFFFF. clr_cnt coincident with a handshake → both counters 0.
- Deassert rst_n during EXACT (idx=2) → out_valid=0 immediately, state IDLE, in_ready=1 after release, no stale result emitted.
